// File: rtl/cache_pkg.sv
// Shared types, constants and PC field helpers for the direct-mapped instruction cache.
package cache_pkg;

  localparam int          DEF_NUM_LINES  = 4;
  localparam int          DEF_LINE_WORDS = 4;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_state_t;

  function automatic logic [31:0] pc_word(input logic [31:0] pc, input int word_bits);
    return (pc >> 2) & ((32'd1 << word_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int word_bits,
                                           input int index_bits);
    return (pc >> (2 + word_bits)) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int word_bits,
                                         input int index_bits);
    return pc >> (2 + word_bits + index_bits);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and line storage: asynchronous read by index, synchronous single-line write.
module icache_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int INDEX_BITS = $clog2(NUM_LINES),
  parameter int TAG_BITS   = 30 - $clog2(LINE_WORDS) - $clog2(NUM_LINES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INDEX_BITS-1:0]    rd_index,
  output logic [TAG_BITS-1:0]      rd_tag,
  output logic                     rd_valid,
  output logic [32*LINE_WORDS-1:0] rd_line,
  input  logic                     we,
  input  logic [INDEX_BITS-1:0]    wr_index,
  input  logic [TAG_BITS-1:0]      wr_tag,
  input  logic [32*LINE_WORDS-1:0] wr_line
);

  logic [NUM_LINES-1:0]     valid_r;
  logic [TAG_BITS-1:0]      tag_r  [NUM_LINES];
  logic [32*LINE_WORDS-1:0] data_r [NUM_LINES];

  // Valid bits: the only state cleared by reset, so a stale fill can never be hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
    end else if (we) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload, written only by a refill.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_line;
    end
  end

  // Combinational read port.
  always_comb begin
    rd_valid = valid_r[rd_index];
    rd_tag   = tag_r[rd_index];
    rd_line  = data_r[rd_index];
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stall and full-line refill on miss.
module instruction_cache
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_req,
  input  logic [31:0]              in_pc,
  output logic [31:0]              out_inst,
  output logic                     out_valid,
  output logic                     out_stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic [32*LINE_WORDS-1:0] mem_rdata
);

  localparam int WORD_BITS  = $clog2(LINE_WORDS);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 30 - WORD_BITS - INDEX_BITS;
  localparam int OFF_BITS   = 2 + WORD_BITS;

  icache_state_t            state_r, state_next_s;
  logic [31:0]              miss_addr_r;
  logic [32*LINE_WORDS-1:0] line_r;

  logic [WORD_BITS-1:0]     word_s;
  logic [INDEX_BITS-1:0]    index_s, rd_index_s, wr_index_s;
  logic [TAG_BITS-1:0]      tag_s, rd_tag_s, wr_tag_s;
  logic                     rd_valid_s, hit_s, miss_start_s, capture_s, we_s;
  logic [32*LINE_WORDS-1:0] rd_line_s;

  // Split the fetch PC and the pending miss address into cache fields.
  always_comb begin
    word_s     = WORD_BITS'(pc_word(in_pc, WORD_BITS));
    index_s    = INDEX_BITS'(pc_index(in_pc, WORD_BITS, INDEX_BITS));
    tag_s      = TAG_BITS'(pc_tag(in_pc, WORD_BITS, INDEX_BITS));
    rd_index_s = index_s;
    wr_index_s = INDEX_BITS'(pc_index(miss_addr_r, WORD_BITS, INDEX_BITS));
    wr_tag_s   = TAG_BITS'(pc_tag(miss_addr_r, WORD_BITS, INDEX_BITS));
  end

  icache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (rd_index_s),
    .rd_tag   (rd_tag_s),
    .rd_valid (rd_valid_s),
    .rd_line  (rd_line_s),
    .we       (we_s),
    .wr_index (wr_index_s),
    .wr_tag   (wr_tag_s),
    .wr_line  (line_r)
  );

  // Hits are only served from IDLE; during a refill every request stalls.
  always_comb begin
    hit_s     = in_req && (state_r == IDLE) && rd_valid_s && (rd_tag_s == tag_s);
    out_valid = hit_s;
    out_stall = in_req && !hit_s;
    if (hit_s) begin
      out_inst = rd_line_s[{word_s, 5'd0} +: 32];
    end else begin
      out_inst = NOP_INST;
    end
  end

  // Refill FSM next-state and memory-side outputs.
  always_comb begin
    state_next_s = state_r;
    miss_start_s = 1'b0;
    capture_s    = 1'b0;
    we_s         = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = 32'd0;
    case (state_r)
      IDLE: begin
        if (in_req && !hit_s) begin
          miss_start_s = 1'b1;
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = miss_addr_r;
        if (mem_ready) begin
          capture_s    = 1'b1;
          state_next_s = FILL;
        end else begin
          state_next_s = REQ;
        end
      end
      FILL: begin
        we_s         = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, line-aligned miss address and captured refill line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      miss_addr_r <= 32'd0;
      line_r      <= '0;
    end else begin
      state_r <= state_next_s;
      if (miss_start_s) begin
        miss_addr_r <= {in_pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
      end
      if (capture_s) begin
        line_r <= mem_rdata;
      end
    end
  end

endmodule
